// File: rtl/alu_seq_if.sv
// Request/response bundle between the control FSM and the sequential ALU.
// The master drives the operation; the slave returns the result and status.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       opcode;
   logic [5:0]       functionCode;
   logic [WIDTH-1:0] nIn1;
   logic [WIDTH-1:0] nIn2;
   logic [WIDTH-1:0] answerOut;
   logic [WIDTH-1:0] answerOut2;
   logic             busy;
   logic             done;
   logic             zero;
   logic             overflow;
   logic             illegal;

   modport master (
      output start, opcode, functionCode, nIn1, nIn2,
      input  answerOut, answerOut2, busy, done, zero, overflow, illegal
   );

   modport slave (
      input  start, opcode, functionCode, nIn1, nIn2,
      output answerOut, answerOut2, busy, done, zero, overflow, illegal
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle R-type ALU: one-cycle arithmetic/logic/compare ops and an
// iterative shift-add signed/unsigned multiply returning a 2*WIDTH product.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic      clock,
   input logic      reset,
   alu_seq_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;

   localparam logic [WIDTH:0]     ONE_X = (WIDTH+1)'(1);
   localparam logic [2*WIDTH-1:0] ONE_P = (2*WIDTH)'(1);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH);

   logic [1:0]       state_reg;
   logic [5:0]       opc_reg;
   logic [5:0]       func_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             req_reg;
   logic [WIDTH:0]   mcand_reg;
   logic [WIDTH-1:0] mplier_reg;
   logic [WIDTH:0]   acc_reg;
   logic             neg_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] ans_reg;
   logic [WIDTH-1:0] ans2_reg;
   logic             done_reg;
   logic             zero_reg;
   logic             ovf_reg;
   logic             ill_reg;

   logic [WIDTH-1:0]   res_next;
   logic               ovf_next;
   logic               ill_next;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH:0]     a_ext;
   logic [WIDTH:0]     b_ext;
   logic [WIDTH:0]     mag_a;
   logic [WIDTH:0]     mag_b;
   logic [WIDTH+1:0]   step_sum;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fin;
   logic               start_mul;

   assign start_mul = (bus.opcode == 6'b000000) &&
                      ((bus.functionCode == F_MULT) || (bus.functionCode == F_MULTU));

   assign sum  = a_reg + b_reg;
   assign diff = a_reg - b_reg;

   always_comb begin
      res_next = '0;
      ovf_next = 1'b0;
      ill_next = 1'b0;
      if (opc_reg != 6'b000000) begin
         ill_next = 1'b1;
      end else begin
         case (func_reg)
            F_ADD: begin
               res_next = sum;
               ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
            end
            F_SUB: begin
               res_next = diff;
               ovf_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);
            end
            F_AND:   res_next = a_reg & b_reg;
            F_OR:    res_next = a_reg | b_reg;
            F_XOR:   res_next = a_reg ^ b_reg;
            F_NOR:   res_next = ~(a_reg | b_reg);
            F_SLT:   res_next = WIDTH'($signed(a_reg) < $signed(b_reg));
            F_SLTU:  res_next = WIDTH'(a_reg < b_reg);
            default: ill_next = 1'b1;
         endcase
      end
   end

   // Magnitudes carry one extra bit so that the most-negative operand negates exactly.
   assign a_ext = {a_reg[WIDTH-1], a_reg};
   assign b_ext = {b_reg[WIDTH-1], b_reg};
   assign mag_a = a_reg[WIDTH-1] ? (~a_ext + ONE_X) : a_ext;
   assign mag_b = b_reg[WIDTH-1] ? (~b_ext + ONE_X) : b_ext;

   assign step_sum = {1'b0, acc_reg} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
   assign prod     = {acc_reg[WIDTH-1:0], mplier_reg};
   assign prod_fin = neg_reg ? (~prod + ONE_P) : prod;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         opc_reg    <= '0;
         func_reg   <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         req_reg    <= 1'b0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         neg_reg    <= 1'b0;
         cnt_reg    <= '0;
         ans_reg    <= '0;
         ans2_reg   <= '0;
         done_reg   <= 1'b0;
         zero_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         ill_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               // A latched single-cycle op retires before any new request is taken.
               if (req_reg) begin
                  req_reg  <= 1'b0;
                  ans_reg  <= res_next;
                  ans2_reg <= '0;
                  zero_reg <= (res_next == '0);
                  ovf_reg  <= ovf_next;
                  ill_reg  <= ill_next;
                  done_reg <= 1'b1;
               end else if (bus.start) begin
                  opc_reg  <= bus.opcode;
                  func_reg <= bus.functionCode;
                  a_reg    <= bus.nIn1;
                  b_reg    <= bus.nIn2;
                  if (start_mul) begin
                     state_reg <= ST_MUL;
                     cnt_reg   <= '0;
                     acc_reg   <= '0;
                  end else begin
                     req_reg <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               if (cnt_reg == '0) begin
                  if (func_reg == F_MULT) begin
                     mcand_reg  <= mag_a;
                     mplier_reg <= mag_b[WIDTH-1:0];
                     neg_reg    <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                  end else begin
                     mcand_reg  <= {1'b0, a_reg};
                     mplier_reg <= b_reg;
                     neg_reg    <= 1'b0;
                  end
                  cnt_reg <= cnt_reg + 1'b1;
               end else begin
                  acc_reg    <= step_sum[WIDTH+1:1];
                  mplier_reg <= {step_sum[0], mplier_reg[WIDTH-1:1]};
                  cnt_reg    <= cnt_reg + 1'b1;
                  if (cnt_reg == LAST_CNT) begin
                     state_reg <= ST_FIN;
                  end
               end
            end
            ST_FIN: begin
               ans_reg   <= prod_fin[WIDTH-1:0];
               ans2_reg  <= prod_fin[2*WIDTH-1:WIDTH];
               zero_reg  <= (prod_fin == '0);
               ovf_reg   <= 1'b0;
               ill_reg   <= 1'b0;
               done_reg  <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.answerOut  = ans_reg;
   assign bus.answerOut2 = ans2_reg;
   assign bus.busy       = (state_reg != ST_IDLE);
   assign bus.done       = done_reg;
   assign bus.zero       = zero_reg;
   assign bus.overflow   = ovf_reg;
   assign bus.illegal    = ill_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq at WIDTH=32 and WIDTH=8, checked
// against an arithmetic reference model of the R-type operation set.
module tb_alu_seq;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   alu_seq_if #(.WIDTH(32)) bus32();
   alu_seq_if #(.WIDTH(8))  bus8();

   alu_seq #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
   alu_seq #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        zero;
      logic        ovf;
      logic        ill;
   } res_t;

   logic [5:0] fn_list [12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                6'b011000, 6'b011001, 6'b111111, 6'b000000};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit is_mul(input logic [5:0] opc, input logic [5:0] fn);
      return (opc == 6'd0) && (fn == 6'b011000 || fn == 6'b011001);
   endfunction

   // Reference: plain signed/unsigned integer arithmetic on w-bit values.
   function automatic res_t model(input int w, input logic [5:0] opc, input logic [5:0] fn,
                                  input logic [31:0] a_in, input logic [31:0] b_in);
      longint unsigned mask = (64'd1 << w) - 64'd1;
      longint unsigned a = {32'd0, a_in} & mask;
      longint unsigned b = {32'd0, b_in} & mask;
      longint sa = (a >= (64'd1 << (w-1))) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      longint sb = (b >= (64'd1 << (w-1))) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      longint max_s = longint'(64'd1 << (w-1)) - 1;
      longint min_s = -max_s - 1;
      longint s;
      longint unsigned p;
      res_t r = '0;
      if (opc != 6'd0) begin
         r.ill = 1'b1;
      end else begin
         case (fn)
            6'b100000: begin s = sa + sb; r.lo = 32'((a + b) & mask); r.ovf = (s > max_s) || (s < min_s); end
            6'b100010: begin s = sa - sb; r.lo = 32'((a - b) & mask); r.ovf = (s > max_s) || (s < min_s); end
            6'b100100: r.lo = 32'(a & b);
            6'b100101: r.lo = 32'(a | b);
            6'b100110: r.lo = 32'(a ^ b);
            6'b100111: r.lo = 32'(~(a | b) & mask);
            6'b101010: r.lo = (sa < sb) ? 32'd1 : 32'd0;
            6'b101011: r.lo = (a < b) ? 32'd1 : 32'd0;
            6'b011000: begin p = longint'(sa * sb); r.lo = 32'(p & mask); r.hi = 32'((p >> w) & mask); end
            6'b011001: begin p = a * b; r.lo = 32'(p & mask); r.hi = 32'((p >> w) & mask); end
            default:   r.ill = 1'b1;
         endcase
      end
      r.zero = (r.lo == 32'd0) && (r.hi == 32'd0);
      return r;
   endfunction

   task automatic drive(input bit w8, input bit st, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      if (w8) begin
         bus8.start = st; bus8.opcode = opc; bus8.functionCode = fn;
         bus8.nIn1 = a[7:0]; bus8.nIn2 = b[7:0];
      end else begin
         bus32.start = st; bus32.opcode = opc; bus32.functionCode = fn;
         bus32.nIn1 = a; bus32.nIn2 = b;
      end
   endtask

   function automatic logic [3:0] status(input bit w8);
      // {busy, zero, overflow, illegal}
      if (w8) return {bus8.busy, bus8.zero, bus8.overflow, bus8.illegal};
      return {bus32.busy, bus32.zero, bus32.overflow, bus32.illegal};
   endfunction

   function automatic logic [63:0] result(input bit w8);
      if (w8) return {24'd0, bus8.answerOut2, 24'd0, bus8.answerOut};
      return {bus32.answerOut2, bus32.answerOut};
   endfunction

   function automatic logic done_of(input bit w8);
      return w8 ? bus8.done : bus32.done;
   endfunction

   task automatic run_op(input bit w8, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input string tag);
      int w = w8 ? 8 : 32;
      res_t e = model(w, opc, fn, a, b);
      int exp_lat = is_mul(opc, fn) ? w + 2 : 1;
      int n = 0;
      bit got = 1'b0;
      @(negedge clock);
      drive(w8, 1'b1, opc, fn, a, b);
      @(posedge clock);
      #1 drive(w8, 1'b0, opc, fn, a, b);
      while (n < 100 && !got) begin
         @(posedge clock);
         #1;
         n++;
         if (done_of(w8)) got = 1'b1;
      end
      check({tag, " latency"}, 64'(n), 64'(exp_lat));
      check({tag, " result"}, result(w8), {e.hi, e.lo});
      check({tag, " flags"}, 64'(status(w8)), {60'd0, 1'b0, e.zero, e.ovf, e.ill});
      $display("op %s w=%0d opc=%0h fn=%0h a=%0h b=%0h -> %0h lat=%0d", tag, w, opc, fn, a, b, result(w8), n);
      @(posedge clock);
      #1 check({tag, " done pulse"}, 64'(done_of(w8)), 64'd0);
   endtask

   initial begin
      logic [5:0]  fn;
      logic [5:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      int          n;
      int          ndone;
      res_t        e;

      reset = 1'b1;
      drive(1'b0, 1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      check("reset result", result(1'b0), 64'd0);
      check("reset status", 64'(status(1'b0)), 64'd0);
      check("reset done", 64'(bus32.done), 64'd0);
      @(negedge clock) reset = 1'b0;

      run_op(1'b0, 6'd0, 6'b100000, 32'h7FFFFFFF, 32'h1, "add_ovf");
      check("add_ovf const", result(1'b0), 64'h0000_0000_8000_0000);
      run_op(1'b0, 6'd0, 6'b100000, 32'hFFFFFFFF, 32'h1, "add_wrap");
      run_op(1'b0, 6'd0, 6'b100010, 32'd5, 32'd7, "sub_neg");
      check("sub_neg const", result(1'b0), 64'h0000_0000_FFFF_FFFE);
      run_op(1'b0, 6'd0, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, "and");
      run_op(1'b0, 6'd0, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, "or");
      run_op(1'b0, 6'd0, 6'b100110, 32'hF0F0F0F0, 32'h0FF00FF0, "xor");
      run_op(1'b0, 6'd0, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, "nor");
      check("nor const", result(1'b0), 64'h0000_0000_000F_000F);
      run_op(1'b0, 6'd0, 6'b101010, 32'hFFFFFFFF, 32'h1, "slt");
      run_op(1'b0, 6'd0, 6'b101011, 32'hFFFFFFFF, 32'h1, "sltu");
      run_op(1'b0, 6'd0, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
      check("multu_max const", result(1'b0), 64'hFFFF_FFFE_0000_0001);
      run_op(1'b0, 6'd0, 6'b011000, 32'hFFFFFFFD, 32'd5, "mult_neg");
      check("mult_neg const", result(1'b0), 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(1'b0, 6'd0, 6'b011000, 32'h80000000, 32'h80000000, "mult_minmin");
      check("mult_minmin const", result(1'b0), 64'h4000_0000_0000_0000);
      run_op(1'b0, 6'd0, 6'b011000, 32'd0, 32'h1234, "mult_zero");
      run_op(1'b0, 6'b000001, 6'b100000, 32'd3, 32'd4, "ill_opc");
      run_op(1'b0, 6'd0, 6'b111111, 32'd3, 32'd4, "ill_fn");
      run_op(1'b1, 6'd0, 6'b011001, 32'hFF, 32'hFF, "multu8");
      check("multu8 const", result(1'b1), 64'h0000_00FE_0000_0001);
      run_op(1'b1, 6'd0, 6'b011000, 32'h80, 32'h80, "mult8_minmin");

      // Reset in the middle of a multiply aborts it without a done pulse.
      @(negedge clock);
      drive(1'b0, 1'b1, 6'd0, 6'b011000, 32'd7, 32'd9);
      @(posedge clock);
      #1 drive(1'b0, 1'b0, 6'd0, 6'b011000, 32'd7, 32'd9);
      repeat (4) @(posedge clock);
      #1 check("mid busy", 64'(bus32.busy), 64'd1);
      @(negedge clock) reset = 1'b1;
      @(posedge clock);
      #1;
      check("abort result", result(1'b0), 64'd0);
      check("abort status", 64'(status(1'b0)), 64'd0);
      @(negedge clock) reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1 if (bus32.done) ndone++;
      end
      check("abort no done", 64'(ndone), 64'd0);
      run_op(1'b0, 6'd0, 6'b100000, 32'd1, 32'd1, "post_abort_add");

      // Inputs thrash during MUL; the latched operands must win.
      e = model(32, 6'd0, 6'b011000, 32'd6, 32'd7);
      @(negedge clock);
      drive(1'b0, 1'b1, 6'd0, 6'b011000, 32'd6, 32'd7);
      @(posedge clock);
      n = 0;
      ndone = 0;
      while (n < 100 && ndone == 0) begin
         #1 drive(1'b0, 1'b1, 6'd0, fn_list[$urandom_range(0, 11)], $urandom, $urandom);
         @(posedge clock);
         n++;
         #1 if (bus32.done) ndone++;
      end
      check("busy latency", 64'(n), 64'd34);
      check("busy result", result(1'b0), {e.hi, e.lo});
      check("busy lo 42", 64'(bus32.answerOut), 64'd42);
      check("busy and done", 64'(bus32.busy), 64'd0);
      drive(1'b0, 1'b1, 6'd0, 6'b100000, 32'd10, 32'd20);
      @(posedge clock);
      #1 drive(1'b0, 1'b0, 6'd0, 6'b100000, 32'd10, 32'd20);
      check("b2b done drop", 64'(bus32.done), 64'd0);
      @(posedge clock);
      #1;
      check("b2b done", 64'(bus32.done), 64'd1);
      check("b2b result", result(1'b0), 64'd30);
      $display("op b2b add 10+20 -> %0h", result(1'b0));

      for (int i = 0; i < 60; i++) begin
         bit w8 = (i % 4 == 3);
         fn  = fn_list[$urandom_range(0, 11)];
         opc = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
         case ($urandom_range(0, 3))
            0:       a = 32'h80000000;
            1:       a = 32'hFFFFFFFF;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
         run_op(w8, opc, fn, a, b, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle R-type ALU in the MIPS datapath.
- Accepts an operation on a start pulse. Single-cycle ops (add/sub/logic/slt) complete in 1 cycle; signed/unsigned multiply runs an iterative shift-add over WIDTH cycles and returns a 2*WIDTH product (hi/lo).
- Signals completion with a one-cycle done pulse plus zero/overflow/illegal flags, so the control FSM can stall on busy instead of assuming fixed timing.

Parameters:
- WIDTH, 32, operand/result width (>=4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- opcode  in  6  must be 6'b000000 (R-type), otherwise illegal.
- functionCode  in  6  operation select.
- nIn1  in  WIDTH  operand A (rs).
- nIn2  in  WIDTH  operand B (rt).
- answerOut  out  WIDTH  result / product low half.
- answerOut2  out  WIDTH  product high half; 0 for non-multiply ops.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse, result valid.
- zero  out  1  answerOut==0 (multiply: full 2*WIDTH product==0).
- overflow  out  1  signed overflow on add/sub; 0 otherwise.
- illegal  out  1  unsupported opcode/functionCode; qualified by done.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; internal operand, accumulator and counter registers 0. Reset asserted mid-multiply aborts the operation, and no done is produced.
- States: IDLE, MUL, FIN.
- IDLE, start=1: latch opcode, functionCode and operands.
  - Single-cycle op or illegal: compute, register outputs, done=1 on the next edge; state stays IDLE.
  - functionCode 011000 (mult, signed) or 011001 (multu): go to MUL, busy=1.
- Function codes:
  - 100000 add: A+B.
  - 100010 sub: A-B.
  - 100100 and.
  - 100101 or.
  - 100110 xor.
  - 100111 nor.
  - 101010 slt: signed A<B → 1, else 0.
  - 101011 sltu: unsigned compare.
  - Any other code: illegal=1, answerOut=answerOut2=0, overflow=0, zero=1.
- add/sub results wrap modulo 2^WIDTH. overflow = operand signs make the result sign impossible (add: same-sign inputs, different-sign result; sub: different-sign inputs, result sign ≠ A).
- MUL:
  - mult: operands converted to magnitudes at latch, product sign recorded as sign(A) xor sign(B). multu: raw operands.
  - Each cycle: if multiplier LSB=1, add multiplicand into the accumulator; shift. Counter runs WIDTH iterations, then go to FIN.
- FIN: apply two's-complement negation of the 2*WIDTH product if the sign flag is set. Drive answerOut=low, answerOut2=high, done=1, overflow=0. Return to IDLE.
- Latency (start sampled at edge 0):
  - Single-cycle ops: done high after edge 1.
  - Multiply: done high after edge WIDTH+2.
- Throughput: a new start is accepted in the same cycle done pulses (IDLE).
- start while busy: ignored, no queueing; latched operands are unaffected by input changes during MUL.
- Outputs hold their last values between operations; only done is a pulse. busy and done are never high together.
- Edge cases:
  - Most-negative × most-negative must produce the exact positive product; the magnitude path is WIDTH+1 bits internally.
  - A multiply by 0 still takes the full latency.

Test Plan:
- Reset mid-multiply: start mult 7×9, assert reset at cycle 5 → busy=0, done never pulses, all outputs 0; a subsequent add 1+1 gives answerOut=2 after 1 cycle.
- Add/sub overflow and wrap:
  - 0x7FFFFFFF+1 → answerOut=0x80000000, overflow=1.
  - 0xFFFFFFFF+1 → 0, zero=1, overflow=0.
  - 5-7 → 0xFFFFFFFE.
- Logic and compare:
  - and/or/xor/nor on 0xF0F0F0F0, 0x0FF00FF0 → 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00 / 0x000F000F.
  - slt(-1,1)=1; sltu(0xFFFFFFFF,1)=0.
- Multiply, checking done exactly WIDTH+2 cycles after start:
  - multu 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
  - mult -3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - mult 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- Busy handling: start and change operands every cycle during MUL of 6×7 → result 42, exactly one done; back-to-back start in the done cycle is accepted.
- Illegal: opcode=000001 add, and functionCode=111111 → illegal=1, done after 1 cycle, answerOut=0. Repeat with WIDTH=8: multu 0xFF×0xFF → hi=0xFE, lo=0x01 after 10 cycles.
